// File: rtl/wash_cycle_sensor_timer.sv
// Input conditioning and phase timers in front of the wash-cycle controller FSM.
// Define FILL_TIMEOUT_EN to build the fill-valve watchdog; otherwise fill_err is tied low.

// Two-flop synchroniser followed by a mismatch-count debouncer with rise detection.
module wash_cycle_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                cnt_d   = '0;
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

// Saturating phase timer; done is a level that holds while the mode stays high.
module wash_cycle_phase_timer #(
    parameter int unsigned LIMIT = 20,
    parameter int unsigned CNT_W = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic mode_i,
    input  logic kill_i,
    output logic done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (mode_i && !kill_i) begin
            if (cnt_q != CNT_W'(LIMIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            done_d = (cnt_d == CNT_W'(LIMIT));
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
endmodule

module wash_cycle_sensor_timer #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned SHAKE_CYCLES = 20,
    parameter int unsigned TURN_CYCLES  = 12,
    parameter int unsigned FILL_TIMEOUT = 50,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start_btn,
    input  logic level_raw,
    input  logic valve,
    input  logic shake_mode,
    input  logic turn_mode,
    output logic start,
    output logic full,
    output logic Time,
    output logic dry,
    output logic fill_err
);
    // Reset asserts asynchronously and is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic btn_level_unused;
    logic level_rise_unused;
    logic overlap;

    assign overlap = shake_mode & turn_mode;

    wash_cycle_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_start (
        .clock  (clock),
        .rst_n  (rst_n),
        .raw_i  (start_btn),
        .level_o(btn_level_unused),
        .rise_o (start)
    );

    wash_cycle_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_level (
        .clock  (clock),
        .rst_n  (rst_n),
        .raw_i  (level_raw),
        .level_o(full),
        .rise_o (level_rise_unused)
    );

    wash_cycle_phase_timer #(
        .LIMIT(SHAKE_CYCLES),
        .CNT_W(CNT_W)
    ) u_shake (
        .clock (clock),
        .rst_n (rst_n),
        .mode_i(shake_mode),
        .kill_i(overlap),
        .done_o(Time)
    );

    wash_cycle_phase_timer #(
        .LIMIT(TURN_CYCLES),
        .CNT_W(CNT_W)
    ) u_turn (
        .clock (clock),
        .rst_n (rst_n),
        .mode_i(turn_mode),
        .kill_i(overlap),
        .done_o(dry)
    );

`ifdef FILL_TIMEOUT_EN
    // Watchdog on an open valve that never sees the tub fill; error clears only when the valve closes.
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             fill_err_q, fill_err_d;

    always_comb begin
        wd_cnt_d   = wd_cnt_q;
        fill_err_d = fill_err_q;
        if (!valve) begin
            wd_cnt_d   = '0;
            fill_err_d = 1'b0;
        end else if (full) begin
            wd_cnt_d = '0;
        end else begin
            if (wd_cnt_q != CNT_W'(FILL_TIMEOUT)) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
            if (wd_cnt_d == CNT_W'(FILL_TIMEOUT)) begin
                fill_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q   <= '0;
            fill_err_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            fill_err_q <= fill_err_d;
        end
    end

    assign fill_err = fill_err_q;
`else
    logic valve_unused;
    assign valve_unused = valve;
    assign fill_err     = 1'b0;
`endif
endmodule

// File: tb/tb_wash_cycle_sensor_timer.sv
// Directed bench for wash_cycle_sensor_timer at default parameters (honours FILL_TIMEOUT_EN).
module tb_wash_cycle_sensor_timer;
    logic clock = 1'b0;
    logic reset_n, start_btn, level_raw, valve, shake_mode, turn_mode;
    logic start, full, Time, dry, fill_err;
    int   total = 0;
    int   bad   = 0;
    int   cnt;

    wash_cycle_sensor_timer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_btn (start_btn),
        .level_raw (level_raw),
        .valve     (valve),
        .shake_mode(shake_mode),
        .turn_mode (turn_mode),
        .start     (start),
        .full      (full),
        .Time      (Time),
        .dry       (dry),
        .fill_err  (fill_err)
    );

    always #5 clock = ~clock;

    // Advance n rising edges; leave the bench 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, int'(start), 0);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_Time"}, int'(Time), 0);
        check({tag, "_dry"}, int'(dry), 0);
        check({tag, "_fill_err"}, int'(fill_err), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n    = 1'b0;
        start_btn  = 1'b0;
        level_raw  = 1'b0;
        valve      = 1'b0;
        shake_mode = 1'b0;
        turn_mode  = 1'b0;
        step(3);
        check_all_zero("por");
        reset_n = 1'b1;
        step(5);
        check_all_zero("idle");

        // Button press: pulse after edge 6 only
        start_btn = 1'b1;
        step(5);
        check("start_e5", int'(start), 0);
        step(1);
        check("start_e6", int'(start), 1);
        step(1);
        check("start_e7", int'(start), 0);
        cnt = 0;
        for (int i = 0; i < 23; i++) begin
            step(1);
            if (start) cnt++;
        end
        check("start_held_pulses", cnt, 0);
        start_btn = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (start) cnt++;
        end
        check("start_release_pulses", cnt, 0);
        start_btn = 1'b1;
        step(2);
        start_btn = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (start) cnt++;
        end
        check("start_glitch_pulses", cnt, 0);

        // Level switch debounce
        level_raw = 1'b1;
        step(5);
        check("full_rise_e5", int'(full), 0);
        step(1);
        check("full_rise_e6", int'(full), 1);
        step(4);
        level_raw = 1'b0;
        step(1);
        level_raw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (!full) cnt++;
        end
        check("full_bounce_drops", cnt, 0);
        level_raw = 1'b0;
        step(5);
        check("full_fall_e5", int'(full), 1);
        step(1);
        check("full_fall_e6", int'(full), 0);
        step(4);

        // Shake timer
        shake_mode = 1'b1;
        step(19);
        check("time_e19", int'(Time), 0);
        step(1);
        check("time_e20", int'(Time), 1);
        step(5);
        check("time_e25", int'(Time), 1);
        shake_mode = 1'b0;
        step(1);
        check("time_drop", int'(Time), 0);
        step(2);
        shake_mode = 1'b1;
        step(10);
        shake_mode = 1'b0;
        step(1);
        check("time_mid_drop", int'(Time), 0);
        shake_mode = 1'b1;
        step(19);
        check("time_rerun_e19", int'(Time), 0);
        step(1);
        check("time_rerun_e20", int'(Time), 1);
        shake_mode = 1'b0;
        step(2);

        // Turn timer and illegal overlap
        turn_mode = 1'b1;
        step(11);
        check("dry_e11", int'(dry), 0);
        step(1);
        check("dry_e12", int'(dry), 1);
        turn_mode = 1'b0;
        step(1);
        check("dry_drop", int'(dry), 0);
        step(2);
        shake_mode = 1'b1;
        turn_mode  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (Time || dry) cnt++;
        end
        check("overlap_active", cnt, 0);
        shake_mode = 1'b0;
        turn_mode  = 1'b0;
        step(2);

`ifdef FILL_TIMEOUT_EN
        // Watchdog with the tub staying empty
        valve = 1'b1;
        step(49);
        check("wd_e49", int'(fill_err), 0);
        step(1);
        check("wd_e50", int'(fill_err), 1);
        step(10);
        check("wd_e60", int'(fill_err), 1);
        level_raw = 1'b1;
        step(8);
        check("wd_full_sticky", int'(fill_err), 1);
        valve = 1'b0;
        step(1);
        check("wd_valve_off", int'(fill_err), 0);
        level_raw = 1'b0;
        step(8);
`else
        valve = 1'b1;
        step(50);
        check("wd_off_e50", int'(fill_err), 0);
        step(10);
        check("wd_off_e60", int'(fill_err), 0);
        valve = 1'b0;
        step(2);
`endif

        // Reset mid-activity with every input high
        start_btn  = 1'b1;
        level_raw  = 1'b1;
        valve      = 1'b1;
        shake_mode = 1'b1;
        turn_mode  = 1'b1;
        step(15);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_assert");
        step(2);
        check_all_zero("rst_held");
        reset_n = 1'b1;
        step(5);
        check("rst_rel_full_a5", int'(full), 0);
        check("rst_rel_start_a5", int'(start), 0);
        step(3);
        check("rst_rel_full_a8", int'(full), 1);
        check("rst_rel_start_a8", int'(start), 1);
        step(1);
        check("rst_rel_start_a9", int'(start), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
